imem_arbiter: RTL

- Shares the single-port instruction memory between two requesters: the core fetch unit (read-only) and the program loader/debug port (read/write).
- Sits between the multicycle control/fetch path and the word-addressed instruction RAM (combinational read, clocked write).
- Grants at most one access per cycle, registers the read data, and returns a one-cycle-latency response tagged to the granted requester.
- Applies fixed priority with an anti-starvation counter, and rejects misaligned or out-of-range addresses.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_rr_stall.sv | 40 ++++
 rtl/imem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_FETCH,
        REQ_LOAD
    } req_id_e;

    // Word-aligned and inside a 2**aw word memory.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned aw);
        logic [ADDR_W-1:0] hi;
        hi = addr >> (aw + 2);
        return (addr[1:0] == 2'b00) && (hi == '0);
    endfunction

endpackage

// File: rtl/imem_rr_stall.sv
// Fixed loader-first priority with a saturating counter that caps how long
// a pending fetch can be starved by back-to-back loader grants.
module imem_rr_stall #(
    parameter int MAX_STALL = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic f_req,
    input  logic l_req,
    output logic f_gnt,
    output logic l_gnt
);

    localparam logic [3:0] STALL_LIM = 4'(MAX_STALL);

    logic [3:0] stall_cnt;

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset_n) begin
            if (l_req && (!f_req || (stall_cnt < STALL_LIM))) begin
                l_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (f_gnt || !f_req) begin
            stall_cnt <= '0;
        end else if (l_gnt && (stall_cnt < STALL_LIM)) begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory shared by core fetch and the loader/debug
// port; one grant per cycle with a registered, requester-tagged response.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int SIZE      = 2048,
    parameter int AW        = $clog2(SIZE),
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    req_id_e           gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              ok;
    logic              is_write;
    logic [DATA_W-1:0] rdata_next;
    logic              f_rvalid_q;
    logic              l_rvalid_q;

    imem_rr_stall #(.MAX_STALL(MAX_STALL)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .f_req   (f_req),
        .l_req   (l_req),
        .f_gnt   (f_gnt),
        .l_gnt   (l_gnt)
    );

    always_comb begin
        gnt_id   = REQ_NONE;
        sel_addr = '0;
        if (l_gnt) begin
            gnt_id   = REQ_LOAD;
            sel_addr = l_addr;
        end else if (f_gnt) begin
            gnt_id   = REQ_FETCH;
            sel_addr = f_addr;
        end
    end

    assign ok         = addr_ok(sel_addr, AW);
    assign is_write   = l_gnt & l_we;
    assign rdata_next = (ok && !is_write) ? mem_rd : '0;

    assign mem_a  = sel_addr;
    assign mem_we = is_write & ok;
    assign mem_wd = l_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f_rvalid_q <= 1'b0;
            f_rdata    <= '0;
            f_err      <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_rdata    <= '0;
            l_err      <= 1'b0;
        end else begin
            f_rvalid_q <= (gnt_id == REQ_FETCH);
            f_rdata    <= (gnt_id == REQ_FETCH) ? rdata_next : '0;
            f_err      <= (gnt_id == REQ_FETCH) && !ok;
            l_rvalid_q <= (gnt_id == REQ_LOAD);
            l_rdata    <= (gnt_id == REQ_LOAD) ? rdata_next : '0;
            l_err      <= (gnt_id == REQ_LOAD) && !ok;
        end
    end

    // A response already in flight when reset arrives must never be seen.
    assign f_rvalid = f_rvalid_q & reset_n;
    assign l_rvalid = l_rvalid_q & reset_n;

endmodule
